// File: rtl/rf_sb_if.sv
// Decode-stage register file bus: writeback port, scoreboard set port and two read ports.
interface rf_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic              busy1;
  logic              busy2;

  modport master (
    output we, wa, wd, ra1, ra2, sb_set, sb_addr,
    input  rd1, rd2, busy1, busy2
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, sb_set, sb_addr,
    output rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/rf_sb.sv
// Two-read / one-write register file with per-register pending-write scoreboard; r0 reads zero.
// Optional macro RF_BYPASS_EN: same-cycle write-through forwarding on both read ports.
module rf_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  rf_sb_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_wr_ok;
  logic              w_set_ok;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_busy1;
  logic              w_busy2;

  assign w_wr_ok  = bus.we && (bus.wa != '0);
  assign w_set_ok = bus.sb_set && (bus.sb_addr != '0);

  // The set follows the clear so a same-address issue (younger) keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.wa]  <= bus.wd;
        r_busy[bus.wa] <= 1'b0;
      end
      if (w_set_ok) begin
        r_busy[bus.sb_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd1   = (bus.ra1 == '0) ? '0 : r_mem[bus.ra1];
    w_rd2   = (bus.ra2 == '0) ? '0 : r_mem[bus.ra2];
    w_busy1 = (bus.ra1 == '0) ? 1'b0 : r_busy[bus.ra1];
    w_busy2 = (bus.ra2 == '0) ? 1'b0 : r_busy[bus.ra2];
`ifdef RF_BYPASS_EN
    if (w_wr_ok && (bus.wa == bus.ra1)) begin
      w_rd1   = bus.wd;
      w_busy1 = 1'b0;
    end
    if (w_wr_ok && (bus.wa == bus.ra2)) begin
      w_rd2   = bus.wd;
      w_busy2 = 1'b0;
    end
`endif
  end

  assign bus.rd1   = w_rd1;
  assign bus.rd2   = w_rd2;
  assign bus.busy1 = w_busy1;
  assign bus.busy2 = w_busy2;
endmodule

// File: tb/tb_rf_sb.sv
// Self-checking bench for rf_sb: directed vector table, async reset, random run vs model, small-parameter instance.
module tb_rf_sb;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rf_sb_if #(.DATA_W(32), .ADDR_W(5)) m_if ();
  rf_sb_if #(.DATA_W(16), .ADDR_W(3)) s_if ();

  rf_sb #(.DATA_W(32), .ADDR_W(5)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
  rf_sb #(.DATA_W(16), .ADDR_W(3)) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        sb;
    logic [4:0]  sa;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
  } vec_t;

  vec_t tbl [14];

  // Reference state: what each register holds and whether a write is outstanding.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic sb, input logic [4:0] sa,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic b1, input logic b2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2; v.sb = sb; v.sa = sa;
    v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [32:0] model_read(input logic [4:0] ra, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] d;
    logic        b;
    d = (ra == 0) ? 32'h0 : m_mem[ra];
    b = (ra == 0) ? 1'b0 : m_busy[ra];
    if (BYP && we && wa != 0 && wa == ra) begin
      d = wd;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic sb, input logic [4:0] sa);
    m_if.we = we; m_if.wa = wa; m_if.wd = wd; m_if.ra1 = ra1; m_if.ra2 = ra2;
    m_if.sb_set = sb; m_if.sb_addr = sa;
  endtask

  // Called just after a rising edge; commits the cycle into the model at the next edge.
  task automatic commit();
    @(posedge clk);
    if (m_if.we && m_if.wa != 0) begin
      m_mem[m_if.wa]  = m_if.wd;
      m_busy[m_if.wa] = 1'b0;
    end
    if (m_if.sb_set && m_if.sb_addr != 0) m_busy[m_if.sb_addr] = 1'b1;
    #1;
  endtask

  task automatic step_s(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra1, input logic [2:0] ra2,
                        input logic [15:0] e1, input logic [15:0] e2, input string tag);
    s_if.we = we; s_if.wa = wa; s_if.wd = wd; s_if.ra1 = ra1; s_if.ra2 = ra2;
    s_if.sb_set = 1'b0; s_if.sb_addr = '0;
    @(negedge clk);
    chk({tag, "_rd1"}, {16'h0, s_if.rd1}, {16'h0, e1});
    chk({tag, "_rd2"}, {16'h0, s_if.rd2}, {16'h0, e2});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] x1;
    logic [32:0] x2;
    logic [4:0]  ra;
    checks = 0;
    errors = 0;
    model_clear();
    drive(1'b0, '0, '0, 5'd5, 5'd7, 1'b0, '0);
    s_if.we = 1'b0; s_if.wa = '0; s_if.wd = '0; s_if.ra1 = '0; s_if.ra2 = '0;
    s_if.sb_set = 1'b0; s_if.sb_addr = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl[0]  = mk(0, 0, 32'h0,        5, 7, 0, 0, 32'h0, 32'h0, 0, 0);
    tbl[1]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 7, 1, 7, 32'h0, 32'h0, 0, 0);
    tbl[4]  = mk(1, 7, 32'h12345678, 0, 7, 0, 0, 32'h0, BYP ? 32'h12345678 : 32'h0, 0, !BYP);
    tbl[5]  = mk(0, 0, 32'h0,        7, 7, 0, 0, 32'h12345678, 32'h12345678, 0, 0);
    tbl[6]  = mk(0, 0, 32'h0,        9, 0, 1, 9, 32'h0, 32'h0, 0, 0);
    tbl[7]  = mk(1, 9, 32'hA5A5A5A5, 9, 9, 1, 9, BYP ? 32'hA5A5A5A5 : 32'h0,
                 BYP ? 32'hA5A5A5A5 : 32'h0, !BYP, !BYP);
    tbl[8]  = mk(0, 0, 32'h0,        9, 0, 0, 0, 32'hA5A5A5A5, 32'h0, 1, 0);
    tbl[9]  = mk(1, 3, 32'h1,        3, 3, 0, 0, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 0, 0);
    tbl[10] = mk(1, 3, 32'h2,        3, 3, 0, 0, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 0, 0);
    tbl[11] = mk(0, 0, 32'h0,        3, 3, 0, 0, 32'h2, 32'h2, 0, 0);
    tbl[12] = mk(1, 5, 32'hDEADBEEF, 0, 7, 0, 0, 32'h0, 32'h12345678, 0, 0);
    tbl[13] = mk(0, 0, 32'h0,        5, 7, 1, 5, 32'hDEADBEEF, 32'h12345678, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2, tbl[i].sb, tbl[i].sa);
      @(negedge clk);
      chk($sformatf("vec%0d_rd1", i), m_if.rd1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), m_if.rd2, tbl[i].e2);
      chk($sformatf("vec%0d_busy1", i), {31'h0, m_if.busy1}, {31'h0, tbl[i].b1});
      chk($sformatf("vec%0d_busy2", i), {31'h0, m_if.busy2}, {31'h0, tbl[i].b2});
      commit();
    end

    // Asynchronous reset pulled mid-cycle.
    drive(1'b0, '0, '0, 5'd5, 5'd7, 1'b0, '0);
    #1;
    chk("pre_rst_rd1", m_if.rd1, 32'hDEADBEEF);
    chk("pre_rst_busy1", {31'h0, m_if.busy1}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_rd1", m_if.rd1, 32'h0);
    chk("rst_busy1", {31'h0, m_if.busy1}, 32'h0);
    chk("rst_rd2", m_if.rd2, 32'h0);
    model_clear();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random run against the reference model; addresses biased low to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1,
            5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)),
            $urandom(),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)),
            $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)));
      @(negedge clk);
      ra = m_if.ra1;
      x1 = model_read(ra, m_if.we, m_if.wa, m_if.wd);
      ra = m_if.ra2;
      x2 = model_read(ra, m_if.we, m_if.wa, m_if.wd);
      chk("rnd_rd1", m_if.rd1, x1[31:0]);
      chk("rnd_rd2", m_if.rd2, x2[31:0]);
      chk("rnd_busy1", {31'h0, m_if.busy1}, {31'h0, x1[32]});
      chk("rnd_busy2", {31'h0, m_if.busy2}, {31'h0, x2[32]});
      commit();
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);

    // Narrow instance: DATA_W=16, ADDR_W=3.
    step_s(1'b1, 3'd7, 16'hBEEF, 3'd0, 3'd0, 16'h0, 16'h0, "s_w7");
    step_s(1'b1, 3'd1, 16'h0001, 3'd0, 3'd0, 16'h0, 16'h0, "s_w1");
    step_s(1'b0, 3'd0, 16'h0,    3'd7, 3'd1, 16'hBEEF, 16'h0001, "s_rdA");
    step_s(1'b0, 3'd0, 16'h0,    3'd1, 3'd7, 16'h0001, 16'hBEEF, "s_rdB");
    step_s(1'b0, 3'd0, 16'h0,    3'd0, 3'd0, 16'h0, 16'h0, "s_r0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
